// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - address map, timer control bit positions and store helpers for io_subsystem
package io_pkg;

    localparam int unsigned LEDR     = 'h000;
    localparam int unsigned LEDG     = 'h010;
    localparam int unsigned HEX_BASE = 'h020;
    localparam int unsigned LCD      = 'h040;
    localparam int unsigned SW       = 'h080;
    localparam int unsigned TCOUNT   = 'h090;
    localparam int unsigned TCMP     = 'h094;
    localparam int unsigned TCTRL    = 'h098;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_PEND = 1;
    localparam int TCTRL_IE   = 2;
    localparam int TCTRL_CLR  = 3;

    localparam logic [6:0] HEX_BLANK = 7'h7F;

    // Expands the 4-bit byte-enable into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] bmask);
        return {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
    endfunction

endpackage

// File: rtl/io_subsystem_if.sv
// rtl/io_subsystem_if.sv - LSU load/store port into the I/O window
interface io_subsystem_if #(parameter int ADDR_W = 12);
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              wren;
    logic [3:0]        bmask;
    logic              rden;
    logic [31:0]       rdata;
    logic              rvalid;

    modport master (output addr, wdata, wren, bmask, rden, input rdata, rvalid);
    modport slave  (input addr, wdata, wren, bmask, rden, output rdata, rvalid);
endinterface

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchroniser plus stability-counter debounce for the switch bank
module sw_debounce #(
    parameter int SW_W            = 17,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SW_W-1:0] sw_raw,
    output logic [SW_W-1:0] sw_deb
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sync_q1, sync_q2, cand, cand_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    always_comb begin
        cand_n = cand;
        cnt_n  = cnt;
        if (sync_q2 != cand) begin
            cand_n = sync_q2;
            cnt_n  = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_n = cnt + 1'b1;
        end
    end

    // The counter saturates, so the hit value is crossed exactly once per stable period.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            cand    <= '0;
            cnt     <= '0;
            sw_deb  <= '0;
        end else begin
            sync_q1 <= sw_raw;
            sync_q2 <= sync_q1;
            cand    <= cand_n;
            cnt     <= cnt_n;
            if (cnt_n == CNT_HIT) sw_deb <= cand_n;
        end
    end
endmodule

// File: rtl/io_subsystem.sv
// rtl/io_subsystem.sv - memory-mapped LED/HEX/LCD outputs, debounced switches and compare timer
module io_subsystem import io_pkg::*; #(
    parameter int ADDR_W          = 12,
    parameter int NUM_HEX         = 8,
    parameter int LEDR_W          = 17,
    parameter int LEDG_W          = 8,
    parameter int SW_W            = 17,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PRESCALE        = 50
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    io_subsystem_if.slave        bus,
    output logic [LEDR_W-1:0]    o_io_ledr,
    output logic [LEDG_W-1:0]    o_io_ledg,
    output logic [7*NUM_HEX-1:0] o_io_hex,
    output logic [31:0]          o_io_lcd,
    input  logic [SW_W-1:0]      i_io_sw,
    output logic                 o_irq
);
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [LEDR_W-1:0] ledr;
    logic [LEDG_W-1:0] ledg;
    logic [6:0]        hex [NUM_HEX];
    logic [31:0]       lcd, tcount, tcmp, wmask, rd_mux;
    logic [PSC_W-1:0]  psc;
    logic              tc_en, tc_ie, tc_pend;
    logic [SW_W-1:0]   sw_deb;

    sw_debounce #(.SW_W(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_debounce (
        .clk    (i_clk),
        .reset  (i_reset),
        .sw_raw (i_io_sw),
        .sw_deb (sw_deb)
    );

    logic [ADDR_W-1:0] word_addr;
    logic [2:0]        hex_idx;
    logic              hex_hit;
    assign word_addr = bus.addr & ~ADDR_W'(3);
    assign hex_idx   = word_addr[4:2];
    assign hex_hit   = (word_addr >= ADDR_W'(HEX_BASE)) &&
                       (word_addr <  ADDR_W'(HEX_BASE + 4 * NUM_HEX));
    assign wmask     = lane_mask(bus.bmask);

    logic wr_ledr, wr_ledg, wr_hex, wr_lcd, wr_tcmp, wr_tctrl;
    assign wr_ledr  = bus.wren && (word_addr == ADDR_W'(LEDR));
    assign wr_ledg  = bus.wren && (word_addr == ADDR_W'(LEDG));
    assign wr_hex   = bus.wren && hex_hit && bus.bmask[0];
    assign wr_lcd   = bus.wren && (word_addr == ADDR_W'(LCD));
    assign wr_tcmp  = bus.wren && (word_addr == ADDR_W'(TCMP));
    assign wr_tctrl = bus.wren && (word_addr == ADDR_W'(TCTRL)) && bus.bmask[0];

    logic ctrl_clr, pend_clr, tick, hit_cmp;
    assign ctrl_clr = wr_tctrl && bus.wdata[TCTRL_CLR];
    assign pend_clr = wr_tctrl && bus.wdata[TCTRL_PEND];
    assign tick     = tc_en && (psc == PSC_LAST) && !ctrl_clr;
    assign hit_cmp  = tick && (tcount == tcmp);

    always_comb begin
        rd_mux = '0;
        if (hex_hit) begin
            for (int k = 0; k < NUM_HEX; k++)
                if (hex_idx == 3'(k)) rd_mux = {25'b0, hex[k]};
        end else begin
            case (word_addr)
                ADDR_W'(LEDR):   rd_mux = 32'(ledr);
                ADDR_W'(LEDG):   rd_mux = 32'(ledg);
                ADDR_W'(LCD):    rd_mux = lcd;
                ADDR_W'(SW):     rd_mux = 32'(sw_deb);
                ADDR_W'(TCOUNT): rd_mux = tcount;
                ADDR_W'(TCMP):   rd_mux = tcmp;
                ADDR_W'(TCTRL):  rd_mux = {29'b0, tc_ie, tc_pend, tc_en};
                default:         rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ledr       <= '0;
            ledg       <= '0;
            lcd        <= '0;
            for (int k = 0; k < NUM_HEX; k++) hex[k] <= HEX_BLANK;
            tcount     <= '0;
            tcmp       <= '0;
            psc        <= '0;
            tc_en      <= 1'b0;
            tc_ie      <= 1'b0;
            tc_pend    <= 1'b0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            bus.rvalid <= bus.rden;
            if (bus.rden) bus.rdata <= rd_mux;

            if (wr_ledr) ledr <= (ledr & ~wmask[LEDR_W-1:0]) | (bus.wdata[LEDR_W-1:0] & wmask[LEDR_W-1:0]);
            if (wr_ledg) ledg <= (ledg & ~wmask[LEDG_W-1:0]) | (bus.wdata[LEDG_W-1:0] & wmask[LEDG_W-1:0]);
            if (wr_lcd)  lcd  <= (lcd & ~wmask) | (bus.wdata & wmask);
            if (wr_tcmp) tcmp <= (tcmp & ~wmask) | (bus.wdata & wmask);
            for (int k = 0; k < NUM_HEX; k++)
                if (wr_hex && hex_idx == 3'(k)) hex[k] <= bus.wdata[6:0];

            if (wr_tctrl) begin
                tc_en <= bus.wdata[TCTRL_EN];
                tc_ie <= bus.wdata[TCTRL_IE];
            end

            // CLR uses the enable held before this store, and it also swallows any tick.
            if (ctrl_clr) begin
                psc    <= '0;
                tcount <= '0;
            end else if (tc_en) begin
                psc <= (psc == PSC_LAST) ? '0 : psc + 1'b1;
                if (tick) tcount <= hit_cmp ? 32'd0 : tcount + 32'd1;
            end

            if (hit_cmp)       tc_pend <= 1'b1;
            else if (pend_clr) tc_pend <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
        assign o_io_hex[7*k +: 7] = hex[k];
    end

    assign o_io_ledr = ledr;
    assign o_io_ledg = ledg;
    assign o_io_lcd  = lcd;
    assign o_irq     = tc_pend & tc_ie;
endmodule
